oddr_tx_sched: RTL and testbench
================================

// Module: oddr_tx_sched
// PURPOSE
//  Burst scheduler for a bank of ODDR primitives on a source-synchronous DDR output bus.
//  - Accepts words on a valid/ready stream.
//  - Splits each word into per-lane rising-edge (D1) and falling-edge (D2) bits.
//  - Frames each burst with lead-in and trail-out clock cycles.
//  - Drives the D1/D2 pair of the forwarded-clock ODDR, plus the lane output enable.
//  Sits between packet logic and the LANES data ODDRs plus one clock ODDR, all clocked by C.
// PARAMETERS
//  LANES     4     number of DDR data lanes (1..32)
//  LEAD_CYC  2     forwarded-clock cycles before the first data word (0..15)
//  TRAIL_CYC 2     forwarded-clock cycles after the last data word (0..15)
//  IDLE_VAL  1'b0  value driven on d1/d2 lanes when no data is scheduled
// PORTS
//  C        in   1        clock (same clock as the ODDR C input)
//  R        in   1        synchronous reset, active-high
//  s_data   in   2*LANES  word; lane i: D1=s_data[i], D2=s_data[LANES+i]
//  s_valid  in   1        word valid
//  s_last   in   1        word is the last of the burst
//  s_ready  out  1        word accepted when s_valid & s_ready
//  d1       out  LANES    to data ODDR D1 inputs
//  d2       out  LANES    to data ODDR D2 inputs
//  ce       out  1        to ODDR CE (all instances)
//  ck_d1    out  1        to clock ODDR D1
//  ck_d2    out  1        to clock ODDR D2
//  oe       out  1        lane output enable (high during LEAD/DATA/TRAIL)
//  busy     out  1        state != IDLE
//  underrun out  1        one-cycle pulse: DATA cycle with s_valid=0
// BEHAVIOUR
//  Reset values: all outputs 0, with d1=d2={LANES{IDLE_VAL}}. R wins over every other event.
//  Registered outputs: d1, d2, ce, ck_d1, ck_d2, oe, underrun. s_ready and busy are decoded from state.
//  ce: 1 from the first cycle after R deasserts; 0 while R is high.
//  Latency: a word accepted in cycle k appears on d1/d2 in cycle k+1.
//  Lane outputs show IDLE_VAL in every cycle with no accepted word.
//  States: IDLE, LEAD, DATA, TRAIL. A 4-bit counter cnt is used in LEAD and TRAIL.
//  IDLE:
//   - s_ready=0, oe=0.
//   - s_valid=1 -> LEAD with cnt=LEAD_CYC-1, or DATA directly if LEAD_CYC=0.
//  LEAD:
//   - s_ready=0, oe=1, lanes=IDLE_VAL.
//   - cnt==0 -> DATA, else cnt--.
//  DATA:
//   - s_ready=1.
//   - accept & s_last -> TRAIL with cnt=TRAIL_CYC-1, or IDLE if TRAIL_CYC=0.
//   - accept & !s_last -> stay in DATA; back-to-back words every cycle.
//   - s_valid=0 -> lanes=IDLE_VAL, underrun=1 next cycle, stay in DATA (burst not aborted).
//  TRAIL:
//   - s_ready=0, oe=1, lanes=IDLE_VAL.
//   - cnt==0 -> IDLE, else cnt--.
//  New burst: s_valid in the cycle of the TRAIL->IDLE transition is sampled in IDLE on the next
//   cycle, so bursts are separated by at least 1 IDLE cycle.
//  Single-word burst (s_last on the first word) is legal: LEAD -> DATA(1 cycle) -> TRAIL.
//  Reset mid-burst: next cycle is IDLE with reset output values. The in-flight word is dropped;
//   no underrun pulse.
// CONFIGURATION
//  ODDR_TX_GATED_CLK_EN defined:
//   - ck_d1=1, ck_d2=0 only in cycles where oe=1; otherwise ck_d1=ck_d2=0 (clock parked low).
//  ODDR_TX_GATED_CLK_EN undefined:
//   - ck_d1=1, ck_d2=0 in every cycle after reset (free-running forwarded clock).
//   - oe still frames the bursts.
//  Both variants: ck_d1=ck_d2=0 while R is high.
// TESTING
//  1 R high 3 cycles, then low
//    -> all outputs 0 during R; ce=1 one cycle later; busy=0; s_ready=0.
//  2 LANES=4, LEAD=2, TRAIL=2; send 3 back-to-back words 0x5A, 0xC3, 0x0F (last)
//    -> oe=1 for 7 cycles.
//    -> d1/d2 = 0/0, 0/0, A/5, 3/C, F/0, 0/0, 0/0.
//  3 DATA state, s_valid dropped for 2 cycles mid-burst
//    -> 2 underrun pulses; lanes=IDLE_VAL in those cycles; burst resumes; word order kept.
//  4 LEAD_CYC=0, TRAIL_CYC=0; single word 0xFF with s_last
//    -> 1 DATA cycle; oe high exactly 1 cycle; busy returns to 0.
//  5 R asserted during DATA with s_valid=1
//    -> next cycle IDLE, oe=0, lanes=IDLE_VAL; next burst after R drops starts with a full LEAD.
//  6 Repeat test 2 with and without ODDR_TX_GATED_CLK_EN
//    -> ck_d1 follows oe when defined; ck_d1 constant 1 when undefined.

Source files
------------

// File: rtl/oddr_tx_sched_if.sv
// Word stream into the ODDR burst scheduler.
// The master drives words and the slave (the scheduler) answers with s_ready.
// A word is accepted in any cycle where s_valid and s_ready are both high.
interface oddr_tx_sched_if #(
  parameter int LANES = 4
) ();

  logic [2*LANES-1:0] s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/oddr_tx_sched.sv
// Burst scheduler for a bank of ODDR primitives on a source-synchronous DDR bus.
//
// Each accepted word is split into per-lane rising-edge (d1) and falling-edge
// (d2) bits. Lane i takes d1 from s_data[i] and d2 from s_data[LANES+i].
// Every burst is framed by LEAD_CYC forwarded-clock cycles before the data and
// TRAIL_CYC cycles after it.
//
// Build option ODDR_TX_GATED_CLK_EN:
//   defined   - the forwarded clock toggles only while oe is high, and is
//               otherwise parked low.
//   undefined - the forwarded clock runs freely in every cycle after reset.
//
// All outputs except s_ready and busy are registered. A word accepted at
// edge k is therefore visible on d1/d2 in the cycle that follows edge k.
module oddr_tx_sched #(
  parameter int   LANES     = 4,
  parameter int   LEAD_CYC  = 2,
  parameter int   TRAIL_CYC = 2,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic                 C,
  input  logic                 R,
  oddr_tx_sched_if.slave       s_if,
  output logic [LANES-1:0]     d1,
  output logic [LANES-1:0]     d2,
  output logic                 ce,
  output logic                 ck_d1,
  output logic                 ck_d2,
  output logic                 oe,
  output logic                 busy,
  output logic                 underrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DATA,
    ST_TRAIL
  } state_t;

  localparam logic [LANES-1:0] LANE_IDLE  = {LANES{IDLE_VAL}};
  localparam logic [3:0]       LEAD_LOAD  = 4'(LEAD_CYC - 1);
  localparam logic [3:0]       TRAIL_LOAD = 4'(TRAIL_CYC - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [LANES-1:0] r_d1;
  logic [LANES-1:0] r_d2;
  logic             r_ce;
  logic             r_ck_d1;
  logic             r_ck_d2;
  logic             r_oe;
  logic             r_underrun;

  logic             w_accept;
  logic             w_active;

  // s_ready and busy are decoded straight from the state so that a word can
  // be accepted in every DATA cycle without a bubble.
  assign s_if.s_ready = (r_state == ST_DATA);
  assign busy         = (r_state != ST_IDLE);
  assign w_accept     = (r_state == ST_DATA) && s_if.s_valid;
  assign w_active     = (r_state != ST_IDLE);

  // Burst state machine together with every registered output.
  // NOTE: all state here uses non-blocking assignments, so each right-hand
  // side reads the value from before the clock edge. This is why oe and the
  // lane registers line up one cycle after the state they describe.
  always_ff @(posedge C) begin
    if (R) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_d1       <= LANE_IDLE;
      r_d2       <= LANE_IDLE;
      r_ce       <= 1'b0;
      r_ck_d1    <= 1'b0;
      r_ck_d2    <= 1'b0;
      r_oe       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_ce       <= 1'b1;
      r_ck_d2    <= 1'b0;
      // oe follows the state one cycle late, matching the latency of the
      // lane data it frames.
      r_oe       <= w_active;
`ifdef ODDR_TX_GATED_CLK_EN
      r_ck_d1    <= w_active;
`else
      r_ck_d1    <= 1'b1;
`endif
      r_underrun <= (r_state == ST_DATA) && !s_if.s_valid;
      r_d1       <= w_accept ? s_if.s_data[LANES-1:0]       : LANE_IDLE;
      r_d2       <= w_accept ? s_if.s_data[2*LANES-1:LANES] : LANE_IDLE;

      case (r_state)
        ST_IDLE: begin
          if (s_if.s_valid) begin
            if (LEAD_CYC == 0) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_LEAD;
              r_cnt   <= LEAD_LOAD;
            end
          end
        end
        ST_LEAD: begin
          if (r_cnt == 4'd0) r_state <= ST_DATA;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_DATA: begin
          // A missing word leaves the burst open; only s_last closes it.
          if (w_accept && s_if.s_last) begin
            if (TRAIL_CYC == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_TRAIL;
              r_cnt   <= TRAIL_LOAD;
            end
          end
        end
        ST_TRAIL: begin
          if (r_cnt == 4'd0) r_state <= ST_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d1       = r_d1;
  assign d2       = r_d2;
  assign ce       = r_ce;
  assign ck_d1    = r_ck_d1;
  assign ck_d2    = r_ck_d2;
  assign oe       = r_oe;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_oddr_tx_sched.sv
// Testbench for oddr_tx_sched.
// DUT A uses LEAD_CYC=2 and TRAIL_CYC=2. DUT B uses LEAD_CYC=0 and
// TRAIL_CYC=0. Both run with LANES=4 and IDLE_VAL=0.
module tb_oddr_tx_sched;

`ifdef ODDR_TX_GATED_CLK_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  localparam int A_LEAD  = 2;
  localparam int A_TRAIL = 2;

  logic C = 1'b0;
  logic R = 1'b1;
  always #5 C = ~C;

  oddr_tx_sched_if #(.LANES(4)) a_if ();
  oddr_tx_sched_if #(.LANES(4)) b_if ();

  logic [3:0] a_d1, a_d2, b_d1, b_d2;
  logic a_ce, a_ck1, a_ck2, a_oe, a_busy, a_ur;
  logic b_ce, b_ck1, b_ck2, b_oe, b_busy, b_ur;

  oddr_tx_sched #(.LANES(4), .LEAD_CYC(A_LEAD), .TRAIL_CYC(A_TRAIL), .IDLE_VAL(1'b0)) u_a (
    .C(C), .R(R), .s_if(a_if), .d1(a_d1), .d2(a_d2), .ce(a_ce), .ck_d1(a_ck1),
    .ck_d2(a_ck2), .oe(a_oe), .busy(a_busy), .underrun(a_ur)
  );

  oddr_tx_sched #(.LANES(4), .LEAD_CYC(0), .TRAIL_CYC(0), .IDLE_VAL(1'b0)) u_b (
    .C(C), .R(R), .s_if(b_if), .d1(b_d1), .d2(b_d2), .ce(b_ce), .ck_d1(b_ck1),
    .ck_d2(b_ck2), .oe(b_oe), .busy(b_busy), .underrun(b_ur)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One table row: inputs applied before an edge, and the outputs expected
  // just after that edge.
  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] data;
    logic       oe;
    logic       rdy;
    logic       busy;
    logic       ur;
    logic [3:0] d1;
    logic [3:0] d2;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one expected beat for every cycle in which oe is high.
  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       ur;
  } beat_t;

  beat_t exp_q[$];
  bit    mon_en = 1'b0;

  function automatic beat_t idle_beat(input logic ur);
    beat_t b;
    b.d1 = 4'h0;
    b.d2 = 4'h0;
    b.ur = ur;
    return b;
  endfunction

  // Random-phase monitor on DUT A, sampled on the falling edge.
  always @(negedge C) begin
    if (mon_en) begin
      if (a_oe) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_oe", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("rnd_beat", {a_d1, a_d2, a_ur}, {b.d1, b.d2, b.ur});
        end
      end else begin
        check("rnd_idle", {a_d1, a_d2, a_ur}, 9'h0);
      end
      check("rnd_ck", {a_ck1, a_ck2, a_ce}, {(GATED ? a_oe : 1'b1), 1'b0, 1'b1});
    end
  end

  // Drive one word on A and wait, with a bound, until it is accepted.
  // Called just after a falling edge.
  task automatic drive_word(input logic [7:0] data, input logic last);
    bit acc;
    int n;
    a_if.s_valid = 1'b1;
    a_if.s_data  = data;
    a_if.s_last  = last;
    n = 0;
    do begin
      acc = a_if.s_ready;
      @(negedge C);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("rnd_accept_timeout", 0, 1);
    a_if.s_valid = 1'b0;
    a_if.s_last  = 1'b0;
  endtask

  // Random burst. The expected oe-window trace is built from the plan first:
  // LEAD idle beats, then one underrun beat per gap followed by the word, and
  // finally TRAIL idle beats.
  task automatic send_burst();
    int nw;
    int gaps[4];
    logic [7:0] words[4];
    nw = $urandom_range(1, 4);
    for (int w = 0; w < nw; w++) begin
      gaps[w]  = (w == 0) ? 0 : $urandom_range(0, 2);
      words[w] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < A_LEAD; i++) exp_q.push_back(idle_beat(1'b0));
    for (int w = 0; w < nw; w++) begin
      beat_t b;
      for (int g = 0; g < gaps[w]; g++) exp_q.push_back(idle_beat(1'b1));
      b.d1 = words[w][3:0];
      b.d2 = words[w][7:4];
      b.ur = 1'b0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < A_TRAIL; i++) exp_q.push_back(idle_beat(1'b0));

    repeat ($urandom_range(0, 3)) @(negedge C);
    for (int w = 0; w < nw; w++) begin
      repeat (gaps[w]) @(negedge C);
      drive_word(words[w], (w == nw - 1));
    end
  endtask

  // Apply one table row and check its outputs.
  task automatic apply_row(input int i);
    vec_t t;
    t = tbl[i];
    a_if.s_valid = t.v;
    a_if.s_last  = t.l;
    a_if.s_data  = t.data;
    @(posedge C);
    #1;
    check($sformatf("vec%0d", i),
          {a_oe, a_if.s_ready, a_busy, a_ur, a_d1, a_d2, a_ck1, a_ck2, a_ce},
          {t.oe, t.rdy, t.busy, t.ur, t.d1, t.d2, (GATED ? t.oe : 1'b1), 1'b0, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int oe_cnt;

    a_if.s_valid = 1'b0; a_if.s_last = 1'b0; a_if.s_data = 8'h00;
    b_if.s_valid = 1'b0; b_if.s_last = 1'b0; b_if.s_data = 8'h00;

    // Vectors for three back-to-back words and for a two-cycle underrun.
    tbl.push_back('{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5});
    tbl.push_back('{1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'hC});
    tbl.push_back('{1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h2});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b1, 8'h43, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});

    // Reset held for three cycles: every output is low.
    repeat (3) begin
      @(posedge C);
      #1;
      check("rst_a", {a_d1, a_d2, a_ce, a_ck1, a_ck2, a_oe, a_busy, a_ur, a_if.s_ready}, 15'h0);
      check("rst_b", {b_d1, b_d2, b_ce, b_ck1, b_ck2, b_oe, b_busy, b_ur, b_if.s_ready}, 15'h0);
    end
    R = 1'b0;
    @(posedge C);
    #1;
    check("post_rst_a", {a_ce, a_busy, a_if.s_ready, a_oe, a_ck1}, {1'b1, 1'b0, 1'b0, 1'b0, !GATED});
    check("post_rst_b", {b_ce, b_busy, b_if.s_ready, b_oe, b_ck1}, {1'b1, 1'b0, 1'b0, 1'b0, !GATED});

    // Table-driven bursts on DUT A.
    oe_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(i);
      if (i < 9 && a_oe) oe_cnt++;
    end
    check("burst_oe_len", oe_cnt, 7);

    // Zero lead and zero trail: a single word with s_last on DUT B.
    b_if.s_valid = 1'b1; b_if.s_last = 1'b1; b_if.s_data = 8'hFF;
    @(posedge C);
    #1;
    check("b_enter", {b_oe, b_if.s_ready, b_busy}, 3'b011);
    @(posedge C);
    #1;
    check("b_word", {b_oe, b_if.s_ready, b_busy, b_d1, b_d2, b_ur}, {3'b100, 4'hF, 4'hF, 1'b0});
    b_if.s_valid = 1'b0; b_if.s_last = 1'b0;
    @(posedge C);
    #1;
    check("b_done", {b_oe, b_busy, b_d1, b_d2}, 10'h0);

    // Reset asserted mid-burst while a word is valid.
    a_if.s_valid = 1'b1; a_if.s_last = 1'b0; a_if.s_data = 8'h65;
    n = 0;
    do begin
      @(posedge C);
      #1;
      n++;
    end while (!a_if.s_ready && n < 10);
    check("mid_reach_data", a_if.s_ready, 1);
    R = 1'b1;
    @(posedge C);
    #1;
    check("mid_rst", {a_oe, a_busy, a_if.s_ready, a_d1, a_d2, a_ur, a_ce, a_ck1}, 14'h0);
    R = 1'b0;
    n = 0;
    do begin
      @(posedge C);
      #1;
      n++;
    end while (!a_if.s_ready && n < 10);
    check("full_lead_after_rst", n, 3);
    a_if.s_last = 1'b1;
    @(posedge C);
    #1;
    check("post_rst_word", {a_d1, a_d2, a_oe}, {4'h5, 4'h6, 1'b1});
    a_if.s_valid = 1'b0; a_if.s_last = 1'b0;
    repeat (3) @(posedge C);
    #1;
    check("post_rst_drained", {a_oe, a_busy}, 2'b00);

    // Random bursts against the reference model.
    @(negedge C);
    mon_en = 1'b1;
    for (int k = 0; k < 30; k++) send_burst();
    n = 0;
    while ((exp_q.size() != 0 || a_oe || a_busy) && n < 100) begin
      @(negedge C);
      n++;
    end
    @(negedge C);
    mon_en = 1'b0;
    check("rnd_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
